// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the MEM stage / debug unit and the data memory arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// whatever drives the requests and models the RAM.
interface dmem_port_arbiter_if #(
   parameter int ADDR_W = 10
) ();

   logic              cpu_re;
   logic              cpu_we;
   logic [1:0]        cpu_size;
   logic              cpu_unsigned;
   logic [ADDR_W-1:0] cpu_addr;
   logic [31:0]       cpu_wdata;
   logic [31:0]       cpu_rdata;
   logic              cpu_rvalid;
   logic              cpu_stall;
   logic              cpu_misalign;

   logic              dbg_req;
   logic              dbg_we;
   logic [ADDR_W-1:0] dbg_addr;
   logic [31:0]       dbg_wdata;
   logic              dbg_gnt;
   logic              dbg_rvalid;
   logic [31:0]       dbg_rdata;

   logic              mem_en;
   logic [3:0]        mem_we;
   logic [ADDR_W-3:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   modport slave (
      input  cpu_re, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_rvalid, cpu_stall, cpu_misalign,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output dbg_gnt, dbg_rvalid, dbg_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output cpu_re, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_rvalid, cpu_stall, cpu_misalign,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  dbg_gnt, dbg_rvalid, dbg_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/dmem_port_arbiter.sv
// Data memory port arbiter: shares one byte-addressable RAM port between the
// pipeline MEM stage (priority) and the debug/loader unit. Steers store byte
// lanes, extracts and extends load data, flags misaligned accesses.
// Optional feature macro DMEM_ARB_STARVE_EN: when defined, a starvation
// counter forces a debug grant (stalling the CPU) after STARVE_LIMIT denied
// cycles. When undefined, debug only gets idle CPU cycles.
module dmem_port_arbiter #(
   parameter int ADDR_W       = 10,
   parameter int STARVE_LIMIT = 8
) (
   input logic                 clk,
   input logic                 reset,
   dmem_port_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      OWN_NONE   = 2'd0,
      OWN_CPU_RD = 2'd1,
      OWN_DBG_RD = 2'd2
   } owner_t;

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
      $error("dmem_port_arbiter: STARVE_LIMIT must be in 1..255");
   end

   logic        cpu_req;
   logic        size_half;
   logic        size_word;
   logic        misaligned;
   logic        dbg_force;
   logic        dbg_win;
   logic        cpu_win;
   logic        cpu_issue;
   logic [3:0]  cpu_be;
   logic [31:0] cpu_wd;

   owner_t      owner;
   logic [1:0]  resp_size;
   logic        resp_unsigned;
   logic [1:0]  resp_off;
   logic [31:0] load_ext;

   assign cpu_req    = bus.cpu_re | bus.cpu_we;
   assign size_half  = (bus.cpu_size == 2'b01);
   assign size_word  = bus.cpu_size[1];
   assign misaligned = (size_half & bus.cpu_addr[0]) |
                       (size_word & (bus.cpu_addr[1:0] != 2'b00));

`ifdef DMEM_ARB_STARVE_EN
   localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

   logic [7:0] starve_cnt;

   // Count consecutive cycles in which a pending debug request was refused.
   always_ff @(posedge clk) begin
      if (!reset) begin
         starve_cnt <= 8'd0;
      end else if (!bus.dbg_req || dbg_win) begin
         starve_cnt <= 8'd0;
      end else if (starve_cnt != 8'hFF) begin
         starve_cnt <= starve_cnt + 8'd1;
      end
   end

   assign dbg_force     = (starve_cnt >= LIMIT);
   assign bus.cpu_stall = cpu_req & dbg_win;
`else
   assign dbg_force     = 1'b0;
   assign bus.cpu_stall = 1'b0;
`endif

   assign dbg_win          = bus.dbg_req & (~cpu_req | dbg_force);
   assign cpu_win          = cpu_req & ~dbg_win;
   assign cpu_issue        = cpu_win & ~misaligned;
   assign bus.dbg_gnt      = dbg_win;
   assign bus.cpu_misalign = cpu_win & misaligned;

   // Byte-lane enables and replicated write data for SB/SH/SW.
   always_comb begin
      cpu_be = 4'b1111;
      cpu_wd = bus.cpu_wdata;
      case (bus.cpu_size)
         2'b00: begin
            cpu_be = 4'b0001 << bus.cpu_addr[1:0];
            cpu_wd = {4{bus.cpu_wdata[7:0]}};
         end
         2'b01: begin
            cpu_be = bus.cpu_addr[1] ? 4'b1100 : 4'b0011;
            cpu_wd = {2{bus.cpu_wdata[15:0]}};
         end
         default: begin
            cpu_be = 4'b1111;
            cpu_wd = bus.cpu_wdata;
         end
      endcase
   end

   // Drive the RAM port from whichever requester won this cycle.
   always_comb begin
      bus.mem_en    = 1'b0;
      bus.mem_we    = 4'b0000;
      bus.mem_addr  = '0;
      bus.mem_wdata = 32'd0;
      if (dbg_win) begin
         bus.mem_en    = 1'b1;
         bus.mem_we    = bus.dbg_we ? 4'b1111 : 4'b0000;
         bus.mem_addr  = bus.dbg_addr[ADDR_W-1:2];
         bus.mem_wdata = bus.dbg_wdata;
      end else if (cpu_issue) begin
         bus.mem_en    = 1'b1;
         bus.mem_we    = bus.cpu_we ? cpu_be : 4'b0000;
         bus.mem_addr  = bus.cpu_addr[ADDR_W-1:2];
         bus.mem_wdata = cpu_wd;
      end
   end

   // Remember who owns next cycle's read word and how to extract it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         owner         <= OWN_NONE;
         resp_size     <= 2'b00;
         resp_unsigned <= 1'b0;
         resp_off      <= 2'b00;
      end else if (dbg_win) begin
         owner         <= bus.dbg_we ? OWN_NONE : OWN_DBG_RD;
         resp_size     <= 2'b10;
         resp_unsigned <= 1'b0;
         resp_off      <= 2'b00;
      end else if (cpu_issue && !bus.cpu_we) begin
         owner         <= OWN_CPU_RD;
         resp_size     <= bus.cpu_size;
         resp_unsigned <= bus.cpu_unsigned;
         resp_off      <= bus.cpu_addr[1:0];
      end else begin
         owner         <= OWN_NONE;
         resp_size     <= 2'b00;
         resp_unsigned <= 1'b0;
         resp_off      <= 2'b00;
      end
   end

   // Pick the byte or half from the returned word and extend it.
   always_comb begin
      load_ext = bus.mem_rdata;
      case (resp_size)
         2'b00: begin
            logic [7:0] b;
            case (resp_off)
               2'b00:   b = bus.mem_rdata[7:0];
               2'b01:   b = bus.mem_rdata[15:8];
               2'b10:   b = bus.mem_rdata[23:16];
               default: b = bus.mem_rdata[31:24];
            endcase
            load_ext = {{24{b[7] & ~resp_unsigned}}, b};
         end
         2'b01: begin
            logic [15:0] h;
            h = resp_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
            load_ext = {{16{h[15] & ~resp_unsigned}}, h};
         end
         default: load_ext = bus.mem_rdata;
      endcase
   end

   // Responses are suppressed while reset is asserted so nothing leaks out
   // of an access that was in flight when reset arrived.
   assign bus.cpu_rvalid = reset & (owner == OWN_CPU_RD);
   assign bus.dbg_rvalid = reset & (owner == OWN_DBG_RD);
   assign bus.cpu_rdata  = bus.cpu_rvalid ? load_ext : 32'd0;
   assign bus.dbg_rdata  = bus.dbg_rvalid ? bus.mem_rdata : 32'd0;

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the single-ported, byte-addressable data memory between the pipeline MEM stage and the debug/loader unit. It steers store byte lanes for SB/SH/SW and extracts and extends load data for LB/LBU/LH/LHU/LW/LWU. The MEM stage has priority. A starvation counter guarantees the debug port forward progress by stalling the CPU for one cycle. Sits between `mem_stage` and the data memory RAM.

## Interface
- ADDR_W, 10: byte-address width; word address = addr[ADDR_W-1:2].
- STARVE_LIMIT, 8: consecutive denied debug-request cycles before debug is forced through (1..255).

- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low.
- cpu_re  in  1  MEM-stage load request.
- cpu_we  in  1  MEM-stage store request; wins if asserted together with cpu_re.
- cpu_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- cpu_unsigned  in  1  zero-extend load (LBU/LHU/LWU).
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  32  store data, right-aligned.
- cpu_rdata  out  32  extended load result; 0 when cpu_rvalid=0.
- cpu_rvalid  out  1  load result valid.
- cpu_stall  out  1  CPU request not serviced this cycle; hold MEM stage.
- cpu_misalign  out  1  misaligned access pulse; access suppressed.
- dbg_req  in  1  debug access request, level; held until dbg_gnt.
- dbg_we  in  1  debug write (full word).
- dbg_addr  in  ADDR_W  debug byte address; [1:0] ignored.
- dbg_wdata  in  32  debug write data.
- dbg_gnt  out  1  debug access issued this cycle.
- dbg_rvalid  out  1  debug read data valid.
- dbg_rdata  out  32  raw memory word.
- mem_en  out  1  memory access enable.
- mem_we  out  4  byte write enables; bit i = bits[8i+7:8i].
- mem_addr  out  ADDR_W-2  word address.
- mem_wdata  out  32  lane-steered write data.
- mem_rdata  in  32  memory read word, valid one cycle after mem_en.

## Operation
- Byte lanes are little-endian: offset 0 maps to bits[7:0].
- Grant per cycle, combinational:
  - Debug wins if dbg_req is high and either no CPU request is present or the starve counter has reached STARVE_LIMIT.
  - Otherwise the CPU wins.
- Memory drive: mem_* come from the winner; if there is no winner, mem_en=0 and mem_we=0.
- cpu_stall=1 when a CPU request is present and debug wins.
- Starve counter:
  - Increments, saturating, in each cycle where dbg_req=1 and the debug request is not granted.
  - Clears on dbg_gnt or when dbg_req=0.
- Stores:
  - SB: mem_we = 1<<addr[1:0]; the byte is replicated to all lanes.
  - SH: mem_we = 0011 or 1100 by addr[1]; the half is replicated.
  - SW: mem_we = 1111.
- Loads: select the byte or half by the registered offset, then sign- or zero-extend per the registered cpu_unsigned. LW and LWU return the word unchanged.
- Misalignment: SH/LH/LHU with addr[0]=1, or a word access with addr[1:0]≠0, suppresses the access (mem_en=0, mem_we=0).
  - cpu_misalign=1 in the request cycle.
  - cpu_rvalid is not asserted.
  - cpu_stall=0.
- Response owner register: NONE, CPU_RD or DBG_RD. It is loaded at issue with {owner, size, unsigned, addr[1:0]} and selects the destination of mem_rdata the next cycle.
  - Writes load NONE.
  - Back-to-back issues are allowed: a new access may issue while the previous response returns.
- Debug writes produce no response; dbg_gnt is the completion indication.

## Timing
- CPU access issue: 0 cycles (same cycle as request, if granted).
- Load result: cpu_rvalid and cpu_rdata in cycle N+1 after issue in cycle N. dbg_rvalid and dbg_rdata follow the same timing.
- dbg_gnt is a one-cycle combinational pulse in the issue cycle. The requester must drop or change dbg_req in the following cycle; if dbg_req is still high, it is a new request.
- Worst-case debug latency: STARVE_LIMIT+1 cycles of continuous CPU traffic.
- Reset (reset=0 at a rising edge):
  - Owner register → NONE; counter → 0.
  - All outputs are 0 in the cycle after reset.
  - A response for an access issued in the reset cycle is discarded; no rvalid is asserted after reset.
- Simultaneous CPU store and debug read at the limit: debug is issued, the store is stalled and retried by the pipeline the next cycle, and the counter clears.

## Configuration
- DMEM_ARB_STARVE_EN defined: starve counter and forced debug grant are present as described.
- Undefined: no counter is present. Debug is granted only in cycles with no CPU request, and cpu_stall is constant 0.

## Test plan
- SB 0x000000FF @0x10, then LB and LBU @0x10 → cpu_rdata 0xFFFFFFFF, then 0x000000FF; mem_we=0001 on the store.
- SH 0x0000CFC7 @0x22 → mem_we=1100, mem_wdata=0xCFC7CFC7; LH → 0xFFFFCFC7, LHU → 0x0000CFC7.
- SW 0xFFFFFFFF @0x30, then LW and LWU → 0xFFFFFFFF; SH @0x21 → cpu_misalign=1, mem_we=0, no cpu_rvalid.
- Continuous CPU loads with dbg_req held: dbg_gnt occurs on cycle STARVE_LIMIT+1 (9), cpu_stall=1 that cycle only, and dbg_rdata is the memory word one cycle later.
- Debug read issued, then reset asserted the next cycle → dbg_rvalid stays 0 and all outputs are 0 after reset.
- With DMEM_ARB_STARVE_EN undefined under the same traffic → dbg_gnt only after CPU requests stop; cpu_stall is never 1.
